imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the LEGv8 decode stage. It takes a 32-bit instruction, classifies its immediate format (I, D, B, CB, IW), and produces an XLEN-wide sign- or zero-extended immediate. Branch offsets can optionally be scaled to a byte offset. Output goes through a STAGES-deep elastic pipeline with valid/ready handshake and flush. It sits between instruction fetch/decode and the ALU/branch-target adders, and replaces the single-cycle combinational extender.

---
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_gen_pipe.sv | 107 ++++++++++
 tb/tb_imm_gen_pipe.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: groups the instruction-in and immediate-out handshakes of imm_gen_pipe.
//   in_valid / in_ready / instruction : upstream (fetch/decode) side
//   out_valid / out_ready / imm / fmt : downstream (ALU / branch-target) side
//   master : the environment driving instructions and consuming immediates
//   slave  : the immediate generator itself
interface imm_gen_pipe_if #(
   parameter int unsigned XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instruction;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm;
   logic [2:0]      fmt;

   modport master (
      output in_valid, instruction, out_ready,
      input  in_ready, out_valid, imm, fmt
   );

   modport slave (
      input  in_valid, instruction, out_ready,
      output in_ready, out_valid, imm, fmt
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: LEGv8 immediate generator followed by a STAGES-deep elastic pipeline.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears valids, imm and fmt)
//   flush : synchronous kill of every in-flight entry and of the current input
//   bus   : imm_gen_pipe_if.slave (instruction in, imm/fmt out, valid/ready both sides)
module imm_gen_pipe #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned STAGES   = 1,
   parameter int unsigned SCALE_BR = 1
) (
   input logic            clk,
   input logic            rst,
   input logic            flush,
   imm_gen_pipe_if.slave  bus
);
   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_D    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_CB   = 3'd4;
   localparam logic [2:0] FMT_IW   = 3'd5;

   logic [31:0]     ins;
   logic [63:0]     full;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;

   assign ins = bus.instruction;

   // Format decode in priority order; the result is built at 64 bits and truncated to XLEN,
   // which also zeroes XLEN=32 wide-move results with hw >= 2.
   always_comb begin
      full    = 64'd0;
      dec_fmt = FMT_NONE;
      if (ins[31:26] == 6'd5 || ins[31:26] == 6'd37) begin
         dec_fmt = FMT_B;
         full    = {{38{ins[25]}}, ins[25:0]};
         if (SCALE_BR == 1) full = full << 2;
      end else if (ins[31:24] == 8'd180 || ins[31:24] == 8'd181 || ins[31:24] == 8'd84) begin
         dec_fmt = FMT_CB;
         full    = {{45{ins[23]}}, ins[23:5]};
         if (SCALE_BR == 1) full = full << 2;
      end else if (ins[31:21] == 11'd1986 || ins[31:21] == 11'd1984) begin
         dec_fmt = FMT_D;
         full    = {{55{ins[20]}}, ins[20:12]};
      end else if (ins[31:22] == 10'd580 || ins[31:22] == 10'd836 ||
                   ins[31:22] == 10'd584 || ins[31:22] == 10'd712) begin
         dec_fmt = FMT_I;
         full    = {52'd0, ins[21:10]};
      end else if (ins[31:23] == 9'd421 || ins[31:23] == 9'd485) begin
         dec_fmt = FMT_IW;
         full    = {48'd0, ins[20:5]} << {ins[22:21], 4'd0};
      end
      dec_imm = full[XLEN-1:0];
   end

   logic [STAGES-1:0] v_q;
   logic [XLEN-1:0]   imm_q [STAGES];
   logic [2:0]        fmt_q [STAGES];
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] up_v;
   logic [XLEN-1:0]   up_imm [STAGES];
   logic [2:0]        up_fmt [STAGES];

   // Stage k may load when it, or any stage after it, has a free slot or the consumer drains.
   // Stage 0 is fed by the decoder, every later stage by its predecessor.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign load[k] = bus.out_ready || !(&v_q[STAGES-1:k]);
      if (k == 0) begin : g_head
         assign up_v[k]   = bus.in_valid;
         assign up_imm[k] = dec_imm;
         assign up_fmt[k] = dec_fmt;
      end else begin : g_body
         assign up_v[k]   = v_q[k-1];
         assign up_imm[k] = imm_q[k-1];
         assign up_fmt[k] = fmt_q[k-1];
      end
   end

   // Stage registers: a loading stage takes its upstream entry (or goes empty); flush empties all.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            imm_q[k] <= '0;
            fmt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               v_q[k] <= up_v[k] && !flush;
               if (up_v[k]) begin
                  imm_q[k] <= up_imm[k];
                  fmt_q[k] <= up_fmt[k];
               end
            end else if (flush) begin
               v_q[k] <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = load[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.imm       = imm_q[STAGES-1];
   assign bus.fmt       = fmt_q[STAGES-1];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe in three configurations
//   u1: XLEN=64 STAGES=1 SCALE_BR=1 (decode table)
//   u2: XLEN=64 STAGES=2 SCALE_BR=1 (backpressure, reset mid-stream)
//   u3: XLEN=32 STAGES=3 SCALE_BR=0 (flush, narrow results, word offsets)
module tb_imm_gen_pipe;
   logic clk = 1'b0;
   logic rst;
   logic fl1, fl2, fl3;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(64)) b1 ();
   imm_gen_pipe_if #(.XLEN(64)) b2 ();
   imm_gen_pipe_if #(.XLEN(32)) b3 ();

   imm_gen_pipe #(.XLEN(64), .STAGES(1), .SCALE_BR(1)) u1 (.clk(clk), .rst(rst), .flush(fl1), .bus(b1));
   imm_gen_pipe #(.XLEN(64), .STAGES(2), .SCALE_BR(1)) u2 (.clk(clk), .rst(rst), .flush(fl2), .bus(b2));
   imm_gen_pipe #(.XLEN(32), .STAGES(3), .SCALE_BR(0)) u3 (.clk(clk), .rst(rst), .flush(fl3), .bus(b3));

   localparam logic [31:0] ADDI = 32'h9101_9041;
   localparam logic [31:0] LDUR = 32'hF85F_8020;
   localparam logic [31:0] CBZ  = 32'hB4FF_FFE0;
   localparam logic [31:0] BR   = 32'h1600_0000;
   localparam logic [31:0] MOVZ = 32'hD2D7_DDE3;
   localparam logic [31:0] MOVK = 32'hF2FF_FFE0;
   localparam logic [31:0] STUR = 32'hF80F_F000;

   logic [31:0] va_ins [12] = '{ADDI, LDUR, CBZ, BR, MOVZ, 32'h0000_0000,
                                32'hB23F_FC00, MOVK, STUR, 32'hB500_0020,
                                32'h547F_FFE0, 32'h95FF_FFFF};
   logic [2:0]  va_fmt [12] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd0,
                                3'd1, 3'd5, 3'd2, 3'd4, 3'd4, 3'd3};
   logic [63:0] va_imm [12] = '{64'd100, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC,
                                64'hFFFF_FFFF_F800_0000, 64'h0000_BEEF_0000_0000, 64'd0,
                                64'h0000_0000_0000_0FFF, 64'hFFFF_0000_0000_0000, 64'd255,
                                64'd4, 64'h0000_0000_000F_FFFC, 64'h0000_0000_07FF_FFFC};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out1(input string tag, input logic v, input logic [2:0] f, input logic [63:0] i);
      chk({tag, " valid"}, 64'(b1.out_valid), 64'(v));
      chk({tag, " fmt"},   64'(b1.fmt), 64'(f));
      chk({tag, " imm"},   b1.imm, i);
   endtask

   task automatic chk_out2(input string tag, input logic v, input logic [2:0] f, input logic [63:0] i);
      chk({tag, " valid"}, 64'(b2.out_valid), 64'(v));
      chk({tag, " fmt"},   64'(b2.fmt), 64'(f));
      chk({tag, " imm"},   b2.imm, i);
   endtask

   task automatic chk_out3(input string tag, input logic v, input logic [2:0] f, input logic [63:0] i);
      chk({tag, " valid"}, 64'(b3.out_valid), 64'(v));
      chk({tag, " fmt"},   64'(b3.fmt), 64'(f));
      chk({tag, " imm"},   64'(b3.imm), i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; fl1 = 1'b0; fl2 = 1'b0; fl3 = 1'b0;
      b1.in_valid = 1'b0; b1.instruction = '0; b1.out_ready = 1'b1;
      b2.in_valid = 1'b0; b2.instruction = '0; b2.out_ready = 1'b1;
      b3.in_valid = 1'b0; b3.instruction = '0; b3.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      // Reset state
      chk_out1("rst u1", 1'b0, 3'd0, 64'd0);
      chk_out3("rst u3", 1'b0, 3'd0, 64'd0);
      chk("rst u1 in_ready", 64'(b1.in_ready), 64'd1);
      chk("rst u2 in_ready", 64'(b2.in_ready), 64'd1);

      // u1: decode table, one instruction per cycle, visible one cycle after acceptance
      for (int i = 0; i < 12; i++) begin
         b1.instruction = va_ins[i];
         b1.in_valid    = 1'b1;
         tick();
         chk_out1($sformatf("u1 vec%0d", i), 1'b1, va_fmt[i], va_imm[i]);
      end
      b1.in_valid = 1'b0;
      tick();
      chk("u1 idle valid", 64'(b1.out_valid), 64'd0);
      tick();
      chk("u1 idle valid2", 64'(b1.out_valid), 64'd0);

      // u2: three back-to-back with consumer stalled for three cycles
      b2.out_ready = 1'b0;
      b2.instruction = ADDI; b2.in_valid = 1'b1;
      #1 chk("u2 rdy0", 64'(b2.in_ready), 64'd1);
      tick();
      b2.instruction = LDUR;
      #1 chk("u2 rdy1", 64'(b2.in_ready), 64'd1);
      tick();
      b2.instruction = BR;
      #1 chk("u2 rdy full", 64'(b2.in_ready), 64'd0);
      chk_out2("u2 stall0", 1'b1, 3'd1, 64'd100);
      tick();
      chk_out2("u2 stall1", 1'b1, 3'd1, 64'd100);
      chk("u2 rdy stall1", 64'(b2.in_ready), 64'd0);
      tick();
      chk_out2("u2 stall2", 1'b1, 3'd1, 64'd100);
      b2.out_ready = 1'b1;
      #1 chk("u2 rdy release", 64'(b2.in_ready), 64'd1);
      tick();
      b2.in_valid = 1'b0;
      chk_out2("u2 drain ldur", 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
      chk_out2("u2 drain b", 1'b1, 3'd3, 64'hFFFF_FFFF_F800_0000);
      tick();
      chk("u2 drained", 64'(b2.out_valid), 64'd0);

      // u3: stream, then flush with an input presented in the flush cycle
      b3.instruction = ADDI; b3.in_valid = 1'b1;
      tick();
      b3.instruction = CBZ;
      tick();
      b3.instruction = MOVZ;
      tick();
      chk_out3("u3 addi", 1'b1, 3'd1, 64'd100);
      b3.instruction = MOVK;
      tick();
      chk_out3("u3 cbz", 1'b1, 3'd4, 64'h0000_0000_FFFF_FFFF);
      b3.instruction = STUR; fl3 = 1'b1;
      #1 chk("u3 rdy flush", 64'(b3.in_ready), 64'd1);
      tick();
      fl3 = 1'b0; b3.in_valid = 1'b0;
      chk("u3 flush0", 64'(b3.out_valid), 64'd0);
      tick();
      chk("u3 flush1", 64'(b3.out_valid), 64'd0);
      tick();
      chk("u3 flush2", 64'(b3.out_valid), 64'd0);
      b3.instruction = MOVZ; b3.in_valid = 1'b1;
      tick();
      b3.instruction = BR;
      tick();
      b3.in_valid = 1'b0;
      chk("u3 lat", 64'(b3.out_valid), 64'd0);
      tick();
      chk_out3("u3 movz32", 1'b1, 3'd5, 64'd0);
      tick();
      chk_out3("u3 b32", 1'b1, 3'd3, 64'h0000_0000_FE00_0000);
      tick();
      chk("u3 empty", 64'(b3.out_valid), 64'd0);

      // u2: reset mid-stream with the consumer stalled
      b2.out_ready = 1'b0;
      b2.instruction = ADDI; b2.in_valid = 1'b1;
      tick();
      b2.instruction = LDUR;
      tick();
      chk("u2 pre-rst valid", 64'(b2.out_valid), 64'd1);
      rst = 1'b1; b2.instruction = ADDI;
      tick();
      rst = 1'b0; b2.in_valid = 1'b0;
      #1;
      chk_out2("u2 post-rst", 1'b0, 3'd0, 64'd0);
      chk("u2 post-rst rdy", 64'(b2.in_ready), 64'd1);
      tick();
      chk("u2 no rst xfer", 64'(b2.out_valid), 64'd0);
      b2.out_ready = 1'b1; b2.instruction = ADDI; b2.in_valid = 1'b1;
      tick();
      b2.in_valid = 1'b0;
      chk("u2 fresh lat", 64'(b2.out_valid), 64'd0);
      tick();
      chk_out2("u2 fresh", 1'b1, 3'd1, 64'd100);
      tick();
      chk("u2 fresh once", 64'(b2.out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
